// File: rtl/rt_fixed_pkg.sv
// Shared Q12.12 fixed-point types and helpers for the ray/AABB slab pipeline.
// Used by the divider wrapper, the slab issue stage and the interval reducer.
package rt_fixed_pkg;

   localparam int DATA_W = 24;
   localparam int FRAC_W = 12;

   typedef logic signed [DATA_W-1:0] fix_t;

   localparam fix_t FIX_ONE = 24'sh001000;
   localparam fix_t FIX_MAX = 24'sh7FFFFF;

   typedef enum logic [1:0] {
      AX_X = 2'd0,
      AX_Y = 2'd1,
      AX_Z = 2'd2
   } axis_e;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_COLLECT = 1'b1
   } collect_state_e;

   // tz1 occupies slot 5; a beat stored there completes the ray
   localparam logic [2:0] LAST_BEAT = 3'd5;

   function automatic fix_t fix_min(input fix_t a, input fix_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic fix_t fix_max(input fix_t a, input fix_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/slab_minmax2.sv
// Combinational signed min/max of one axis' pair of slab distances.
module slab_minmax2
   import rt_fixed_pkg::*;
(
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [DATA_W-1:0] mn,
   output logic signed [DATA_W-1:0] mx
);

   logic a_lt_b_s;

   assign a_lt_b_s = (a < b);
   assign mn       = a_lt_b_s ? a : b;
   assign mx       = a_lt_b_s ? b : a;

endmodule

// File: rtl/slab_interval_reduce.sv
// Collects six slab distances per ray, reduces them to (tnear, tfar, hit) and
// presents the result on a valid/ready port with a single holding register.
module slab_interval_reduce
   import rt_fixed_pkg::*;
#(
   parameter int   ID_W  = 8,
   parameter fix_t T_MAX = FIX_MAX
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_tvalid,
   input  logic              in_first,
   input  logic [ID_W-1:0]   in_id,
   input  logic [DATA_W-1:0] in_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ID_W-1:0]   out_id,
   output logic [DATA_W-1:0] out_tnear,
   output logic [DATA_W-1:0] out_tfar,
   output logic              out_hit,
   output logic              err_resync,
   output logic              err_overflow
);

   collect_state_e  state_r, state_nxt_s;
   logic [2:0]      beat_cnt_r;
   fix_t            slot_r [0:5];
   logic [ID_W-1:0] id_r;
   logic            reduce_v_r;

   logic            start_s, store_s, done_s, resync_s;

   fix_t            mn_x_s, mx_x_s, mn_y_s, mx_y_s, mn_z_s, mx_z_s;
   fix_t            tnear_s, tfar_s;

   logic            red_v_r;
   fix_t            red_tnear_r, red_tfar_r;
   logic [ID_W-1:0] red_id_r;
   logic            load_s;

   assign start_s = in_tvalid & in_first;

   // Collect FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= S_IDLE;
      else     state_r <= state_nxt_s;
   end

   // Collect FSM next-state logic; a first beat always (re)starts a ray
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start_s) state_nxt_s = S_COLLECT;
            else         state_nxt_s = S_IDLE;
         end
         S_COLLECT: begin
            if (start_s)                                      state_nxt_s = S_COLLECT;
            else if (in_tvalid && (beat_cnt_r == LAST_BEAT)) state_nxt_s = S_IDLE;
            else                                              state_nxt_s = S_COLLECT;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Collect FSM control outputs
   always_comb begin
      store_s  = 1'b0;
      done_s   = 1'b0;
      resync_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (in_tvalid && !in_first) resync_s = 1'b1;
            else                        resync_s = 1'b0;
         end
         S_COLLECT: begin
            if (start_s) begin
               resync_s = 1'b1;
            end else if (in_tvalid) begin
               store_s = 1'b1;
               done_s  = (beat_cnt_r == LAST_BEAT);
            end else begin
               store_s = 1'b0;
            end
         end
         default: resync_s = 1'b0;
      endcase
   end

   // Slot registers, beat counter and ray tag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_r <= 3'd0;
         id_r       <= '0;
         reduce_v_r <= 1'b0;
         err_resync <= 1'b0;
         for (int i = 0; i < 6; i++) slot_r[i] <= '0;
      end else begin
         reduce_v_r <= done_s;
         err_resync <= resync_s;
         if (start_s) begin
            slot_r[0]  <= fix_t'(in_result);
            id_r       <= in_id;
            beat_cnt_r <= 3'd1;
         end else if (store_s) begin
            for (int i = 1; i < 6; i++)
               if (beat_cnt_r == 3'(i)) slot_r[i] <= fix_t'(in_result);
            beat_cnt_r <= done_s ? 3'd0 : beat_cnt_r + 3'd1;
         end
      end
   end

   slab_minmax2 u_mm_x (.a(slot_r[0]), .b(slot_r[1]), .mn(mn_x_s), .mx(mx_x_s));
   slab_minmax2 u_mm_y (.a(slot_r[2]), .b(slot_r[3]), .mn(mn_y_s), .mx(mx_y_s));
   slab_minmax2 u_mm_z (.a(slot_r[4]), .b(slot_r[5]), .mn(mn_z_s), .mx(mx_z_s));

   assign tnear_s = fix_max(fix_max(mn_x_s, mn_y_s), mn_z_s);
   assign tfar_s  = fix_min(fix_min(fix_min(mx_x_s, mx_y_s), mx_z_s), T_MAX);

   // Reduce stage; slots may be refilled by the next ray on this same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         red_v_r     <= 1'b0;
         red_tnear_r <= '0;
         red_tfar_r  <= '0;
         red_id_r    <= '0;
      end else begin
         red_v_r <= reduce_v_r;
         if (reduce_v_r) begin
            red_tnear_r <= tnear_s;
            red_tfar_r  <= tfar_s;
            red_id_r    <= id_r;
         end
      end
   end

   assign load_s = red_v_r & (~out_valid | out_ready);

   // Output holding register; a result arriving while stalled is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_id       <= '0;
         out_tnear    <= '0;
         out_tfar     <= '0;
         out_hit      <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         if (load_s) begin
            out_valid <= 1'b1;
            out_id    <= red_id_r;
            out_tnear <= red_tnear_r;
            out_tfar  <= red_tfar_r;
            out_hit   <= (red_tnear_r <= red_tfar_r) && !red_tfar_r[DATA_W-1];
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (red_v_r && out_valid && !out_ready) err_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_slab_interval_reduce.sv
// Scoreboard bench for slab_interval_reduce: directed rays with hand-computed
// intervals, backpressure/overflow, resync, reset mid-ray and randomized rays.
module tb_slab_interval_reduce;

   typedef struct packed {
      logic [7:0]  id;
      logic [23:0] tnear;
      logic [23:0] tfar;
      logic        hit;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_tvalid = 1'b0;
   logic        in_first = 1'b0;
   logic [7:0]  in_id = 8'h00;
   logic [23:0] in_result = 24'h000000;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_id;
   logic [23:0] out_tnear;
   logic [23:0] out_tfar;
   logic        out_hit;
   logic        err_resync;
   logic        err_overflow;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb_q [$];
   exp_t        got_e;
   logic [23:0] vec [0:5];
   logic        rand_rdy = 1'b0;
   logic        hold_prev = 1'b0;
   exp_t        held;

   slab_interval_reduce dut (
      .clk(clk), .rst(rst),
      .in_tvalid(in_tvalid), .in_first(in_first), .in_id(in_id), .in_result(in_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_tnear(out_tnear), .out_tfar(out_tfar), .out_hit(out_hit),
      .err_resync(err_resync), .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic beat(input logic first, input logic [7:0] id, input logic [23:0] v);
      in_tvalid = 1'b1;
      in_first  = first;
      in_id     = id;
      in_result = v;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_tvalid = 1'b0;
      in_first  = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_ray(input logic [7:0] id);
      for (int i = 0; i < 6; i++) beat(i == 0, id, vec[i]);
      in_tvalid = 1'b0;
      in_first  = 1'b0;
   endtask

   task automatic set_vec(input logic [23:0] a, b, c, d, e, f);
      vec[0] = a; vec[1] = b; vec[2] = c; vec[3] = d; vec[4] = e; vec[5] = f;
   endtask

   task automatic push(input logic [7:0] id, input logic [23:0] tn, input logic [23:0] tf,
                       input logic hit);
      exp_t e;
      e.id = id; e.tnear = tn; e.tfar = tf; e.hit = hit;
      sb_q.push_back(e);
   endtask

   // Independent reference: running max of axis minima, running min of axis maxima
   function automatic exp_t model(input logic [7:0] id);
      exp_t m;
      int   tn, tf, p, q, lo, hi;
      tn = -8388608;
      tf = 8388607;
      for (int a = 0; a < 3; a++) begin
         p  = int'($signed(vec[2*a]));
         q  = int'($signed(vec[2*a+1]));
         lo = (p < q) ? p : q;
         hi = (p < q) ? q : p;
         if (lo > tn) tn = lo;
         if (hi < tf) tf = hi;
      end
      m.id    = id;
      m.tnear = tn[23:0];
      m.tfar  = tf[23:0];
      m.hit   = (tn <= tf) && (tf >= 0);
      return m;
   endfunction

   function automatic logic [23:0] rand_val();
      case ($urandom_range(0, 5))
         0:       return 24'h7FFFFF;
         1:       return 24'h800000;
         2:       return 24'h000000;
         3:       return 24'($urandom_range(0, 24'h00FFFF));
         4:       return 24'h000000 - 24'($urandom_range(0, 24'h00FFFF));
         default: return 24'($urandom);
      endcase
   endfunction

   task automatic wait_empty(input string name, input int budget);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         n++;
      end
      check(name, 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor: pops on every transfer and checks that stalled outputs hold
   always @(negedge clk) begin
      if (!rst && hold_prev) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", 32'({out_id, out_hit} ^ {held.id, held.hit}) |
               32'(out_tnear ^ held.tnear) | 32'(out_tfar ^ held.tfar), 32'd0);
      end
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: id %0h tnear %0h, none expected", out_id, out_tnear);
         end else begin
            got_e = sb_q.pop_front();
            check("out_id",    32'(out_id),    32'(got_e.id));
            check("out_tnear", 32'(out_tnear), 32'(got_e.tnear));
            check("out_tfar",  32'(out_tfar),  32'(got_e.tfar));
            check("out_hit",   32'(out_hit),   32'(got_e.hit));
         end
      end
      hold_prev = !rst && out_valid && !out_ready;
      held.id = out_id; held.tnear = out_tnear; held.tfar = out_tfar; held.hit = out_hit;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_tnear) | 32'(out_tfar) | 32'(out_id) | 32'(out_hit), 32'd0);
      check("rst_errs", 32'({err_resync, err_overflow}), 32'd0);
      rst = 1'b0;
      idle(2);

      // Hit ray plus latency
      set_vec(24'hFFF000, 24'h002000, 24'h000800, 24'h003000, 24'h001000, 24'hFFF800);
      push(8'h11, 24'h000800, 24'h001000, 1'b1);
      send_ray(8'h11);
      check("lat_n0", 32'(out_valid), 32'd0);
      idle(1);
      check("lat_n1", 32'(out_valid), 32'd0);
      idle(1);
      check("lat_n2", 32'(out_valid), 32'd1);
      wait_empty("drain_hit", 20);

      // Miss
      set_vec(24'h002000, 24'h003000, 24'h000000, 24'h001000, 24'hFFF000, 24'h004000);
      push(8'h22, 24'h002000, 24'h001000, 1'b0);
      send_ray(8'h22);
      wait_empty("drain_miss", 20);

      // Behind origin: tnear=-3.0, tfar=min(-2,-1,-1.5)=-2.0
      set_vec(24'hFFD000, 24'hFFE000, 24'hFFC000, 24'hFFF000, 24'hFFB000, 24'hFFE800);
      push(8'h33, 24'hFFD000, 24'hFFE000, 1'b0);
      send_ray(8'h33);
      wait_empty("drain_behind", 20);
      check("no_ovf_yet", 32'(err_overflow), 32'd0);

      // Back-to-back with out_ready=1: both delivered
      set_vec(24'hFFF000, 24'h002000, 24'h000800, 24'h003000, 24'h001000, 24'hFFF800);
      push(8'h41, 24'h000800, 24'h001000, 1'b1);
      send_ray(8'h41);
      set_vec(24'h002000, 24'h003000, 24'h000000, 24'h001000, 24'hFFF000, 24'h004000);
      push(8'h42, 24'h002000, 24'h001000, 1'b0);
      send_ray(8'h42);
      wait_empty("drain_b2b", 20);

      // Back-to-back under backpressure: A held, B dropped
      out_ready = 1'b0;
      set_vec(24'hFFF000, 24'h002000, 24'h000800, 24'h003000, 24'h001000, 24'hFFF800);
      push(8'h51, 24'h000800, 24'h001000, 1'b1);
      send_ray(8'h51);
      set_vec(24'h002000, 24'h003000, 24'h000000, 24'h001000, 24'hFFF000, 24'h004000);
      send_ray(8'h52);
      idle(3);
      check("ovf_set", 32'(err_overflow), 32'd1);
      check("ovf_held_id", 32'(out_id), 32'h51);
      out_ready = 1'b1;
      wait_empty("drain_ovf", 20);
      idle(4);
      check("ovf_no_b", 32'(out_valid), 32'd0);
      check("ovf_sticky", 32'(err_overflow), 32'd1);

      // Stray beat in idle
      beat(1'b0, 8'h60, 24'h001000);
      check("resync_stray", 32'(err_resync), 32'd1);
      idle(1);
      check("resync_pulse", 32'(err_resync), 32'd0);

      // Restart on beat 4
      beat(1'b1, 8'h61, 24'h005000);
      beat(1'b0, 8'h61, 24'h006000);
      beat(1'b0, 8'h61, 24'h007000);
      check("resync_quiet", 32'(err_resync), 32'd0);
      set_vec(24'h000000, 24'h004000, 24'h001000, 24'h002000, 24'h003000, 24'h000800);
      push(8'h62, 24'h001000, 24'h002000, 1'b1);
      beat(1'b1, 8'h62, vec[0]);
      check("resync_restart", 32'(err_resync), 32'd1);
      for (int i = 1; i < 6; i++) beat(1'b0, 8'h62, vec[i]);
      idle(1);
      wait_empty("drain_resync", 20);
      idle(4);

      // Reset mid-ray with a held output pending
      out_ready = 1'b0;
      set_vec(24'h001000, 24'h002000, 24'h001000, 24'h002000, 24'h001000, 24'h002000);
      send_ray(8'h70);
      idle(3);
      check("pre_rst_held", 32'(out_valid), 32'd1);
      for (int i = 0; i < 3; i++) beat(i == 0, 8'h71, vec[i]);
      in_tvalid = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_data", 32'(out_tnear) | 32'(out_tfar) | 32'(out_id) | 32'(out_hit), 32'd0);
      check("rst_mid_errs", 32'({err_resync, err_overflow}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      set_vec(24'hFFF000, 24'h002000, 24'h000800, 24'h003000, 24'h001000, 24'hFFF800);
      push(8'h72, 24'h000800, 24'h001000, 1'b1);
      send_ray(8'h72);
      wait_empty("drain_post_rst", 20);
      idle(4);

      // Randomized rays against the reference model
      rand_rdy = 1'b1;
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 6; i++) vec[i] = rand_val();
         sb_q.push_back(model(8'(r + 8'h80)));
         send_ray(8'(r + 8'h80));
         idle($urandom_range(0, 2));
         wait_empty("drain_rand", 200);
      end
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      idle(4);
      check("final_ovf", 32'(err_overflow), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
